// File: rtl/riscv_uc_pkg.sv
// riscv_uc_pkg: opcodes, ALU op codes, mux selects and state encoding shared by the
// RISC-V multicycle control unit.
package riscv_uc_pkg;
   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [1:0] ALUOP_ADD = 2'b00;
   localparam logic [1:0] ALUOP_BR  = 2'b01;
   localparam logic [1:0] ALUOP_R   = 2'b10;
   localparam logic [1:0] ALUOP_I   = 2'b11;
   localparam logic [1:0] MUX1_RS2   = 2'd0;
   localparam logic [1:0] MUX1_IMM   = 2'd1;
   localparam logic [1:0] MUX2_MEM   = 2'd0;
   localparam logic [1:0] MUX2_ALU   = 2'd1;
   localparam logic [1:0] MUX3_PC1   = 2'd0;
   localparam logic [1:0] MUX3_PCIMM = 2'd1;
   localparam logic [1:0] MUX4_ALU   = 2'd0;
   localparam logic [1:0] MUX4_RS2   = 2'd1;
   typedef enum logic [3:0] {
      S_RST     = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_ALU_R   = 4'd3,
      S_ALU_I   = 4'd4,
      S_LD_ADDR = 4'd5,
      S_LD_WB   = 4'd6,
      S_ST      = 4'd7,
      S_BR_CMP  = 4'd8,
      S_BR_UPD  = 4'd9,
      S_HALT    = 4'd10,
      S_NOP     = 4'd11
   } state_t;
endpackage

// File: rtl/riscv_uc.sv
// riscv_uc: multicycle control FSM sequencing fetch/decode/execute/memory/writeback;
// Moore outputs except the branch-taken PC select in S_BR_UPD.
module riscv_uc
   import riscv_uc_pkg::*;
#(
   parameter bit HALT_ON_ILLEGAL = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic       branch,
   output logic       pc_load,
   output logic       pc_reset,
   output logic       mem_re,
   output logic       mem_we,
   output logic       reg_file_write,
   output logic [1:0] alu_op,
   output logic [1:0] select_mux_1,
   output logic [1:0] select_mux_2,
   output logic [1:0] select_mux_3,
   output logic [1:0] select_mux_4,
   output logic       halt,
   output logic [3:0] state_dbg
);
   state_t state, next_state;

   always_ff @(posedge clk or posedge reset)
      if (reset) state <= S_RST;
      else state <= next_state;

   always_comb begin
      next_state = state;
      case (state)
         S_RST:    next_state = S_FETCH;
         S_FETCH:  next_state = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OPC_R:      next_state = S_ALU_R;
               OPC_I:      next_state = S_ALU_I;
               OPC_LOAD:   next_state = S_LD_ADDR;
               OPC_STORE:  next_state = S_ST;
               OPC_BRANCH: next_state = S_BR_CMP;
               default:    next_state = HALT_ON_ILLEGAL ? S_HALT : S_NOP;
            endcase
         end
         S_LD_ADDR: next_state = S_LD_WB;
         S_BR_CMP:  next_state = S_BR_UPD;
         S_HALT:    next_state = S_HALT;
         S_ALU_R, S_ALU_I, S_LD_WB, S_ST, S_BR_UPD, S_NOP: next_state = S_FETCH;
         default:   next_state = S_RST;
      endcase
   end

   always_comb begin
      pc_load        = 1'b0;
      pc_reset       = 1'b0;
      mem_re         = 1'b0;
      mem_we         = 1'b0;
      reg_file_write = 1'b0;
      alu_op         = ALUOP_ADD;
      select_mux_1   = MUX1_RS2;
      select_mux_2   = MUX2_MEM;
      select_mux_3   = MUX3_PC1;
      select_mux_4   = MUX4_ALU;
      halt           = 1'b0;
      case (state)
         S_RST: pc_reset = 1'b1;
         S_ALU_R, S_ALU_I: begin
            alu_op         = (state == S_ALU_R) ? ALUOP_R : ALUOP_I;
            select_mux_1   = (state == S_ALU_R) ? MUX1_RS2 : MUX1_IMM;
            select_mux_2   = MUX2_ALU;
            reg_file_write = 1'b1;
            pc_load        = 1'b1;
         end
         S_LD_ADDR: begin
            select_mux_1 = MUX1_IMM;
            mem_re       = 1'b1;
         end
         S_LD_WB: begin
            select_mux_1   = MUX1_IMM;
            mem_re         = 1'b1;
            select_mux_2   = MUX2_MEM;
            reg_file_write = 1'b1;
            pc_load        = 1'b1;
         end
         S_ST: begin
            select_mux_1 = MUX1_IMM;
            select_mux_4 = MUX4_RS2;
            mem_we       = 1'b1;
            pc_load      = 1'b1;
         end
         S_BR_CMP: alu_op = ALUOP_BR;
         S_BR_UPD: begin
            // branch is registered in the datapath, so it is valid here, one cycle after the compare
            alu_op       = ALUOP_BR;
            pc_load      = 1'b1;
            select_mux_3 = branch ? MUX3_PCIMM : MUX3_PC1;
         end
         S_NOP:  pc_load = 1'b1;
         S_HALT: halt = 1'b1;
         default: ;
      endcase
   end

   assign state_dbg = state;
endmodule

// File: tb/tb_riscv_uc.sv
// tb_riscv_uc: scoreboard bench driving a halting and a NOP-on-illegal instance in lockstep.
module tb_riscv_uc;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [6:0] opcode = 7'd0;
   logic branch = 1'b0;
   logic pl_h, pr_h, re_h, we_h, rw_h, hl_h, pl_n, pr_n, re_n, we_n, rw_n, hl_n;
   logic [1:0] ao_h, m1_h, m2_h, m3_h, m4_h, ao_n, m1_n, m2_n, m3_n, m4_n;
   logic [3:0] st_h, st_n;
   logic [19:0] qa[$], qb[$];
   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   riscv_uc #(.HALT_ON_ILLEGAL(1'b1)) dut_h (
      .clk(clk), .reset(reset), .opcode(opcode), .branch(branch),
      .pc_load(pl_h), .pc_reset(pr_h), .mem_re(re_h), .mem_we(we_h), .reg_file_write(rw_h),
      .alu_op(ao_h), .select_mux_1(m1_h), .select_mux_2(m2_h), .select_mux_3(m3_h),
      .select_mux_4(m4_h), .halt(hl_h), .state_dbg(st_h));

   riscv_uc #(.HALT_ON_ILLEGAL(1'b0)) dut_n (
      .clk(clk), .reset(reset), .opcode(opcode), .branch(branch),
      .pc_load(pl_n), .pc_reset(pr_n), .mem_re(re_n), .mem_we(we_n), .reg_file_write(rw_n),
      .alu_op(ao_n), .select_mux_1(m1_n), .select_mux_2(m2_n), .select_mux_3(m3_n),
      .select_mux_4(m4_n), .halt(hl_n), .state_dbg(st_n));

   function automatic logic [19:0] mk(input logic [3:0] st, input logic pl, pr, re, we, rw,
                                      input logic [1:0] ao, m1, m2, m3, m4, input logic h);
      return {st, pl, pr, re, we, rw, ao, m1, m2, m3, m4, h};
   endfunction

   // expected vector per state: {state, pc_load, pc_reset, mem_re, mem_we, rfw, alu_op, mux1..4, halt}
   logic [19:0] E_RST, E_FETCH, E_DEC, E_ALU_R, E_ALU_I, E_LD_A, E_LD_WB, E_ST, E_BR_C, E_BR_T, E_BR_N, E_HALT, E_NOP;
   initial begin
      E_RST   = mk(4'd0,  0, 1, 0, 0, 0, 2'b00, 2'd0, 2'd0, 2'd0, 2'd0, 0);
      E_FETCH = mk(4'd1,  0, 0, 0, 0, 0, 2'b00, 2'd0, 2'd0, 2'd0, 2'd0, 0);
      E_DEC   = mk(4'd2,  0, 0, 0, 0, 0, 2'b00, 2'd0, 2'd0, 2'd0, 2'd0, 0);
      E_ALU_R = mk(4'd3,  1, 0, 0, 0, 1, 2'b10, 2'd0, 2'd1, 2'd0, 2'd0, 0);
      E_ALU_I = mk(4'd4,  1, 0, 0, 0, 1, 2'b11, 2'd1, 2'd1, 2'd0, 2'd0, 0);
      E_LD_A  = mk(4'd5,  0, 0, 1, 0, 0, 2'b00, 2'd1, 2'd0, 2'd0, 2'd0, 0);
      E_LD_WB = mk(4'd6,  1, 0, 1, 0, 1, 2'b00, 2'd1, 2'd0, 2'd0, 2'd0, 0);
      E_ST    = mk(4'd7,  1, 0, 0, 1, 0, 2'b00, 2'd1, 2'd0, 2'd0, 2'd1, 0);
      E_BR_C  = mk(4'd8,  0, 0, 0, 0, 0, 2'b01, 2'd0, 2'd0, 2'd0, 2'd0, 0);
      E_BR_T  = mk(4'd9,  1, 0, 0, 0, 0, 2'b01, 2'd0, 2'd0, 2'd1, 2'd0, 0);
      E_BR_N  = mk(4'd9,  1, 0, 0, 0, 0, 2'b01, 2'd0, 2'd0, 2'd0, 2'd0, 0);
      E_HALT  = mk(4'd10, 0, 0, 0, 0, 0, 2'b00, 2'd0, 2'd0, 2'd0, 2'd0, 1);
      E_NOP   = mk(4'd11, 1, 0, 0, 0, 0, 2'b00, 2'd0, 2'd0, 2'd0, 2'd0, 0);
   end

   always @(negedge clk) begin
      logic [19:0] e, a;
      cyc++;
      if (qa.size() > 0) begin
         e = qa.pop_front();
         a = {st_h, pl_h, pr_h, re_h, we_h, rw_h, ao_h, m1_h, m2_h, m3_h, m4_h, hl_h};
         vectors++;
         if (a !== e) begin
            miscompares++;
            $display("FAIL dut_halt cycle %0d: got %05h expected %05h", cyc, a, e);
         end
      end
      if (qb.size() > 0) begin
         e = qb.pop_front();
         a = {st_n, pl_n, pr_n, re_n, we_n, rw_n, ao_n, m1_n, m2_n, m3_n, m4_n, hl_n};
         vectors++;
         if (a !== e) begin
            miscompares++;
            $display("FAIL dut_nop cycle %0d: got %05h expected %05h", cyc, a, e);
         end
      end
   end

   task automatic step2(input logic [19:0] a, input logic [19:0] b);
      qa.push_back(a);
      qb.push_back(b);
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic [19:0] x);
      step2(x, x);
   endtask

   initial begin
      @(posedge clk);
      #1;
      step(E_RST);
      step(E_RST);
      reset = 1'b0;
      step(E_RST);
      step(E_FETCH);
      opcode = 7'b0110011;
      step(E_DEC);
      step(E_ALU_R);
      step(E_FETCH);
      opcode = 7'b0010011;
      step(E_DEC);
      step(E_ALU_I);
      step(E_FETCH);
      opcode = 7'b0000011;
      step(E_DEC);
      step(E_LD_A);
      step(E_LD_WB);
      step(E_FETCH);
      opcode = 7'b0100011;
      step(E_DEC);
      step(E_ST);
      step(E_FETCH);
      opcode = 7'b1100011;
      step(E_DEC);
      step(E_BR_C);
      branch = 1'b1;
      step(E_BR_T);
      branch = 1'b0;
      step(E_FETCH);
      step(E_DEC);
      step(E_BR_C);
      step(E_BR_N);
      step(E_FETCH);
      opcode = 7'b1111111;
      step(E_DEC);
      step2(E_HALT, E_NOP);
      for (int i = 0; i < 20; i++)
         step2(E_HALT, (i % 3 == 0) ? E_FETCH : (i % 3 == 1) ? E_DEC : E_NOP);
      #2 reset = 1'b1;
      step(E_RST);
      step(E_RST);
      reset = 1'b0;
      step(E_RST);
      step(E_FETCH);
      opcode = 7'b0110011;
      step(E_DEC);
      step(E_ALU_R);
      step(E_FETCH);
      repeat (2) @(negedge clk);
      if (qa.size() != 0 || qb.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d/%0d expected vectors left unchecked", qa.size(), qb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
